// File: rtl/ctrl_pkg.sv
// Shared encodings and the execute-bound control bundle for the decode control pipe.
package ctrl_pkg;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] IMM_DP  = 2'b00;
  localparam logic [1:0] IMM_MEM = 2'b01;
  localparam logic [1:0] IMM_BR  = 2'b10;

  localparam logic [1:0] RSRC_DP  = 2'b00;
  localparam logic [1:0] RSRC_BR  = 2'b01;
  localparam logic [1:0] RSRC_MEM = 2'b10;

  // FlagWrite: [1] = NZ, [0] = CV
  localparam logic [1:0] FW_NONE = 2'b00;
  localparam logic [1:0] FW_NZ   = 2'b10;
  localparam logic [1:0] FW_ALL  = 2'b11;

  localparam logic [3:0] COND_AL = 4'b1110;

  typedef struct packed {
    logic       pcsrc;
    logic       regwrite;
    logic       memwrite;
    logic       memtoreg;
    logic       branch;
    logic       alusrc;
    logic       nowrite;
    logic [1:0] alucontrol;
    logic [1:0] flagwrite;
    logic [3:0] cond;
    logic       valid;
  } ctrl_e_t;

  function automatic ctrl_e_t ctrl_bubble(input logic [3:0] cond);
    ctrl_bubble      = '0;
    ctrl_bubble.cond = cond;
  endfunction

endpackage

// File: rtl/ctrl_e_reg.sv
// Pipeline flop with sync reset, sync clear (both load CLR_VAL) and hold enable.
module ctrl_e_reg
  import ctrl_pkg::*;
#(
  parameter int           W       = $bits(ctrl_e_t),
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) q <= CLR_VAL;
    else if (en)    q <= d;
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Decode-stage control unit and the ID/EX control register feeding Execute.
module decode_ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter logic [3:0] BUBBLE_COND = COND_AL,
  parameter bit         SUPPORT_CMP = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] InstrD,
  input  logic        StallE,
  input  logic        FlushE,
  output logic [1:0]  RegSrcD,
  output logic [1:0]  ImmSrcD,
  output logic        IllegalD,
  output logic        PCSrcE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        MemtoRegE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic        NoWriteE,
  output logic [1:0]  ALUControlE,
  output logic [1:0]  FlagWriteE,
  output logic [3:0]  CondE,
  output logic        ValidE
);

  localparam ctrl_e_t BUBBLE_E = ctrl_bubble(BUBBLE_COND);

  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd, cmd;
  logic       unused_bits;

  assign op    = InstrD[27:26];
  assign funct = InstrD[25:20];
  assign rd    = InstrD[15:12];
  assign cmd   = funct[4:1];
  assign unused_bits = ^{InstrD[19:16], InstrD[11:0]};

  ctrl_e_t dec, d_e, q_e;
  logic    illegal;

  always_comb begin
    dec      = '0;
    dec.cond = InstrD[31:28];
    illegal  = 1'b0;
    ImmSrcD  = IMM_DP;
    RegSrcD  = RSRC_DP;
    unique case (op)
      OP_DP: begin
        dec.alusrc   = funct[5];
        dec.regwrite = 1'b1;
        unique case (cmd)
          CMD_ADD: dec.alucontrol = ALU_ADD;
          CMD_SUB: dec.alucontrol = ALU_SUB;
          CMD_AND: dec.alucontrol = ALU_AND;
          CMD_ORR: dec.alucontrol = ALU_ORR;
          CMD_CMP: begin
            dec.alucontrol = ALU_SUB;
            dec.regwrite   = 1'b0;
            dec.nowrite    = 1'b1;
            // a compare that does not set flags has no effect at all
            illegal        = !SUPPORT_CMP || !funct[0];
          end
          default: illegal = 1'b1;
        endcase
        if (funct[0])
          dec.flagwrite = (cmd == CMD_AND || cmd == CMD_ORR) ? FW_NZ : FW_ALL;
      end
      OP_MEM: begin
        ImmSrcD        = IMM_MEM;
        RegSrcD        = RSRC_MEM;
        dec.alusrc     = 1'b1;
        dec.alucontrol = funct[3] ? ALU_ADD : ALU_SUB;
        dec.regwrite   = funct[0];
        dec.memtoreg   = funct[0];
        dec.memwrite   = !funct[0];
      end
      OP_BR: begin
        ImmSrcD        = IMM_BR;
        RegSrcD        = RSRC_BR;
        dec.branch     = 1'b1;
        dec.alusrc     = 1'b1;
        dec.alucontrol = ALU_ADD;
      end
      default: illegal = 1'b1;
    endcase
    dec.pcsrc = (rd == 4'hF && dec.regwrite) || dec.branch;
    dec.valid = !illegal;
  end

  // illegal encodings must never reach Execute with any side effect enabled
  always_comb begin
    d_e = dec;
    if (illegal) begin
      d_e.pcsrc     = 1'b0;
      d_e.regwrite  = 1'b0;
      d_e.memwrite  = 1'b0;
      d_e.branch    = 1'b0;
      d_e.flagwrite = FW_NONE;
    end
  end

  assign IllegalD = illegal;

  ctrl_e_reg #(.W($bits(ctrl_e_t)), .CLR_VAL(BUBBLE_E)) u_id_ex (
    .clk (CLK),
    .rst (RESET),
    .clr (FlushE),
    .en  (!StallE),
    .d   (d_e),
    .q   (q_e)
  );

  assign PCSrcE      = q_e.pcsrc;
  assign RegWriteE   = q_e.regwrite;
  assign MemWriteE   = q_e.memwrite;
  assign MemtoRegE   = q_e.memtoreg;
  assign BranchE     = q_e.branch;
  assign ALUSrcE     = q_e.alusrc;
  assign NoWriteE    = q_e.nowrite;
  assign ALUControlE = q_e.alucontrol;
  assign FlagWriteE  = q_e.flagwrite;
  assign CondE       = q_e.cond;
  assign ValidE      = q_e.valid;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Randomized scoreboard bench: stimulus pushes expected Execute contents, monitor pops and compares.
module tb_decode_ctrl_pipe;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] InstrD = '0;
  logic        StallE = 1'b0;
  logic        FlushE = 1'b0;
  logic [1:0]  RegSrcD, ImmSrcD, ALUControlE, FlagWriteE;
  logic        IllegalD, PCSrcE, RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE, NoWriteE, ValidE;
  logic [3:0]  CondE;

  always #5 CLK = ~CLK;

  decode_ctrl_pipe dut (
    .CLK(CLK), .RESET(RESET), .InstrD(InstrD), .StallE(StallE), .FlushE(FlushE),
    .RegSrcD(RegSrcD), .ImmSrcD(ImmSrcD), .IllegalD(IllegalD),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .NoWriteE(NoWriteE), .ALUControlE(ALUControlE),
    .FlagWriteE(FlagWriteE), .CondE(CondE), .ValidE(ValidE)
  );

  // full=1: every field is defined (legal instruction or bubble)
  typedef struct {
    bit       full;
    bit       pcsrc, regw, memw, m2r, br, alusrc, nowr, valid;
    bit [1:0] aluc, fw;
    bit [3:0] cond;
  } exp_t;

  exp_t q[$];
  exp_t cur;
  int   vectors = 0;
  int   miscompares = 0;

  localparam logic [31:0] I_ADDS = 32'hE0921003;
  localparam logic [31:0] I_CMP  = 32'hE3510005;
  localparam logic [31:0] I_STR  = 32'hE5810004;
  localparam logic [31:0] I_BNE  = 32'h1A000002;
  localparam logic [31:0] I_ILL  = 32'hEC000000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t bubble();
    exp_t e = '{default: 0};
    e.full = 1; e.cond = 4'b1110;
    return e;
  endfunction

  // Reference: instruction semantics from the ISA tables
  task automatic model(input logic [31:0] ins, output exp_t e, output bit legal,
                       output bit [1:0] imm, output bit [1:0] rsel);
    bit [5:0] f = ins[25:20];
    bit       s = f[0];
    e = '{default: 0};
    e.cond = ins[31:28];
    legal = 1; imm = 0; rsel = 0;
    if (ins[27:26] == 2'b00) begin
      e.alusrc = f[5];
      if      (f[4:1] == 4'b0100) begin e.aluc = 0; e.regw = 1; e.fw = s ? 3 : 0; end
      else if (f[4:1] == 4'b0010) begin e.aluc = 1; e.regw = 1; e.fw = s ? 3 : 0; end
      else if (f[4:1] == 4'b0000) begin e.aluc = 2; e.regw = 1; e.fw = s ? 2 : 0; end
      else if (f[4:1] == 4'b1100) begin e.aluc = 3; e.regw = 1; e.fw = s ? 2 : 0; end
      else if (f[4:1] == 4'b1010 && s) begin e.aluc = 1; e.nowr = 1; e.fw = 3; end
      else legal = 0;
    end else if (ins[27:26] == 2'b01) begin
      imm = 1; rsel = 2; e.alusrc = 1; e.aluc = f[3] ? 0 : 1;
      if (f[0]) begin e.regw = 1; e.m2r = 1; end
      else e.memw = 1;
    end else if (ins[27:26] == 2'b10) begin
      imm = 2; rsel = 1; e.br = 1; e.alusrc = 1;
    end else legal = 0;
    if (legal) e.pcsrc = (ins[15:12] == 4'hF && e.regw) || e.br;
    else begin e.regw = 0; e.memw = 0; e.br = 0; e.fw = 0; e.pcsrc = 0; end
    e.valid = legal;
    e.full  = legal;
  endtask

  task automatic step(input logic [31:0] ins, input bit st, input bit fl, input bit rs);
    exp_t d; bit legal; bit [1:0] imm, rsel;
    @(negedge CLK);
    InstrD = ins; StallE = st; FlushE = fl; RESET = rs;
    #1;
    model(ins, d, legal, imm, rsel);
    chk("IllegalD", IllegalD, !legal);
    if (ins[27:26] != 2'b11) begin
      chk("ImmSrcD", ImmSrcD, imm);
      chk("RegSrcD", RegSrcD, rsel);
    end
    if (rs || fl) cur = bubble();
    else if (!st) cur = d;
    q.push_back(cur);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("ValidE", ValidE, e.valid);
        chk("CondE", CondE, e.cond);
        chk("RegWriteE", RegWriteE, e.regw);
        chk("MemWriteE", MemWriteE, e.memw);
        chk("BranchE", BranchE, e.br);
        chk("PCSrcE", PCSrcE, e.pcsrc);
        chk("FlagWriteE", FlagWriteE, e.fw);
        if (e.full) begin
          chk("ALUSrcE", ALUSrcE, e.alusrc);
          chk("ALUControlE", ALUControlE, e.aluc);
          chk("MemtoRegE", MemtoRegE, e.m2r);
          chk("NoWriteE", NoWriteE, e.nowr);
        end
      end
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins = $urandom;
    int r = $urandom_range(0, 9);
    logic [3:0] cmds [5] = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010};
    if ($urandom_range(0, 3) == 0) ins[15:12] = 4'hF;
    if (r <= 4) begin
      ins[27:26] = 2'b00;
      if ($urandom_range(0, 6) != 0) ins[24:21] = cmds[$urandom_range(0, 4)];
    end
    else if (r <= 6) ins[27:26] = 2'b01;
    else if (r <= 8) ins[27:26] = 2'b10;
    else             ins[27:26] = 2'b11;
    return ins;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    cur = bubble();
    step(32'h0, 0, 0, 1);
    step(32'h0, 0, 0, 1);
    step(32'h0, 1, 0, 0);          // nothing loaded after reset
    step(I_ADDS, 0, 0, 0);
    step(I_CMP,  0, 0, 0);
    step(I_STR,  0, 0, 0);
    step(I_BNE,  0, 0, 0);
    step(I_ADDS, 0, 0, 0);
    repeat (3) step(I_STR, 1, 0, 0);
    step(I_STR, 1, 1, 0);          // flush beats stall
    step(I_ILL, 0, 0, 0);
    step(I_ADDS, 0, 0, 0);
    step(I_CMP, 1, 0, 1);          // reset beats stall
    step(I_CMP, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      step(rand_instr(), $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 39) == 0);
    @(negedge CLK);
    StallE = 1'b0; FlushE = 1'b0; RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    chk("scoreboard_drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_pipe.md
Name: decode_ctrl_pipe

Overview:
- Decode-stage control unit plus the ID/EX control pipeline register. It is the producer of every control and condition field that the execute-stage conditional-gating logic consumes.
- It decodes the instruction in Decode and generates the Decode-local selects.
- It registers the execute-bound controls (PCSrc, RegWrite, MemWrite, Branch, FlagWrite, NoWrite, Cond) into Execute, with hazard-driven stall and flush.

Parameters:
- BUBBLE_COND, 4'b1110, value loaded into CondE on reset or flush (AL; harmless because all write enables are zero).
- SUPPORT_CMP, 1, when 0, cmd 1010 decodes as illegal instead of CMP.

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- InstrD  in  32  instruction in Decode; fields: Cond=[31:28], Op=[27:26], Funct=[25:20], Rd=[15:12].
- StallE  in  1  hold the ID/EX register.
- FlushE  in  1  load a bubble into the ID/EX register.
- RegSrcD  out  2  register-read selects; combinational.
- ImmSrcD  out  2  extend-unit select; combinational.
- IllegalD  out  1  undefined encoding in Decode; combinational.
- PCSrcE, RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE, NoWriteE  out  1 each  registered controls.
- ALUControlE  out  2  registered ALU operation.
- FlagWriteE  out  2  registered; [1]=NZ, [0]=CV.
- CondE  out  4  registered condition field.
- ValidE  out  1  1 = Execute holds a real decoded instruction.

Behaviour:
- Decode (combinational, Decode stage):
  - Op=00, data processing: I=Funct[5], cmd=Funct[4:1], S=Funct[0]. ALUSrc=I. ImmSrc=00. RegSrc=00. RegWrite=1 except CMP.
  - ALUControl by cmd: ADD 0100→00, SUB 0010→01, AND 0000→10, ORR 1100→11, CMP 1010→01.
  - Any other cmd is illegal.
  - FlagWrite: S=0→00; S=1 with ADD/SUB/CMP→11; S=1 with AND/ORR→10.
  - CMP: NoWrite=1, RegWrite=0. CMP with S=0 is illegal.
  - Op=01, memory: L=Funct[0], U=Funct[3]. ALUSrc=1. ImmSrc=01. RegSrc=10. ALUControl = U?00:01. FlagWrite=00.
    - L=1 (LDR): RegWrite=1, MemtoReg=1.
    - L=0 (STR): MemWrite=1, RegWrite=0.
  - Op=10, branch: Branch=1, ALUSrc=1, ImmSrc=10, RegSrc=01, ALUControl=00, no writes.
  - Op=11: IllegalD=1.
  - Any illegal decode forces every write enable, Branch, PCSrc and FlagWrite to 0 before registering, and ValidE is loaded 0.
  - PCSrcD = (Rd==4'hF & RegWriteD) | BranchD.
  - CondD = InstrD[31:28] is passed unmodified. Cond=1111 is not filtered here.
- ID/EX register, on posedge CLK, priority in order:
  1. RESET: all registered outputs 0, CondE=BUBBLE_COND, ValidE=0.
  2. FlushE: same bubble values as reset.
  3. StallE: hold all values.
  4. Otherwise: load the decoded values; ValidE = ~IllegalD.
- Simultaneous FlushE and StallE: flush wins.
- RESET asserted mid-stall: bubble loaded; the stall is ignored that cycle.
- Latency: one cycle Decode→Execute. RegSrcD, ImmSrcD and IllegalD have zero latency.
- A bubble never asserts RegWriteE, MemWriteE, BranchE, PCSrcE or FlagWriteE, regardless of CondE.

Decomposition:
- Package ctrl_pkg:
  - op encodings: OP_DP, OP_MEM, OP_BR.
  - cmd constants: CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_CMP.
  - ALUControl encodings.
  - ImmSrc/RegSrc encodings.
  - COND_AL.
  - packed struct ctrl_e_t containing all execute-bound fields.
- Sub-module ctrl_e_reg: parameterised-width flop with synchronous reset, synchronous clear and enable. It holds ctrl_e_t, and the clear value is supplied as a parameter.

Test Plan:
- Reset: RESET=1 for 2 cycles, then 0 with no instruction loaded → all controls 0, CondE=1110, ValidE=0.
- ADDS R1,R2,R3 (32'hE0921003) loaded →
  - next cycle: RegWriteE=1, ALUControlE=00, FlagWriteE=11, CondE=1110, NoWriteE=0, PCSrcE=0.
- CMP R1,#5 (32'hE3510005) → RegWriteE=0, NoWriteE=1, FlagWriteE=11, ALUSrcE=1, ALUControlE=01.
- STR R0,[R1,#4] (32'hE5810004) → MemWriteE=1, RegWriteE=0, ImmSrcD=01, RegSrcD=10.
- BNE (32'h1A000002) → BranchE=1, PCSrcE=1, CondE=0001, ImmSrcD=10.
- Stall/flush precedence:
  - ADDS with StallE=1 for 3 cycles, then FlushE=1 and StallE=1 together → outputs held during the stall; all controls 0 and CondE=1110 after the flush.
  - InstrD=32'hEC000000 (Op=11) → IllegalD=1; next cycle ValidE=0 and all enables 0.
